// File: rtl/arith_pkg.sv
// Shared arithmetic constants and types for the datapath leaf blocks.
package arith_pkg;

  localparam int unsigned MULT8_W  = 8;
  localparam int unsigned MULT8_PW = 16;

  typedef logic [15:0] prod16_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the multiplier's ripple rows.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum/majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/array_mult8_gen.sv
// Unsigned 8x8 array multiplier with a registered 16-bit product.
// Row 0 passes the first partial-product row through.
// Rows 1..7 are ripple full-adder rows.
// Optional feature macro: ARRAY_MULT8_IN_REG_EN. When it is defined, the operands and
// in_valid are registered before the array, giving a latency of 2 instead of 1.
module array_mult8_gen
  import arith_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MULT8_W-1:0] x,
  input  logic [MULT8_W-1:0] y,
  input  logic               in_valid,
  output prod16_t            P,
  output logic               out_valid
);

  // Operands as seen by the array.
  logic [MULT8_W-1:0] x_a;
  logic [MULT8_W-1:0] y_a;
  logic               v_a;

`ifdef ARRAY_MULT8_IN_REG_EN
  logic [MULT8_W-1:0] x_q;
  logic [MULT8_W-1:0] y_q;
  logic               v_q;

  // Input stage: capture the operands and their qualifier every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      x_q <= x;
      y_q <= y;
      v_q <= in_valid;
    end
  end

  assign x_a = x_q;
  assign y_a = y_q;
  assign v_a = v_q;
`else
  assign x_a = x;
  assign y_a = y;
  assign v_a = in_valid;
`endif

  // Array grid. Every cell exposes its sum bit as s.
  // The adder cells also expose their carry-out as g_fa.co.
  // In row i, the "a" input of column j is the sum bit of column j+1 in the row above.
  // Column 7 instead takes the carry-out of the row above.
  for (genvar i = 0; i < MULT8_W; i++) begin : g_row
    for (genvar j = 0; j < MULT8_W; j++) begin : g_col
      logic s;
      if (i == 0) begin : g_pass
        assign s = x_a[j] & y_a[0];
      end else begin : g_fa
        logic a;
        logic ci;
        logic co;
        if (j == MULT8_W - 1) begin : g_msb
          if (i == 1) begin : g_first
            assign a = 1'b0;
          end else begin : g_chain
            assign a = g_row[i-1].g_col[MULT8_W-1].g_fa.co;
          end
        end else begin : g_mid
          assign a = g_row[i-1].g_col[j+1].s;
        end
        if (j == 0) begin : g_lsb
          assign ci = 1'b0;
        end else begin : g_rip
          assign ci = g_row[i].g_col[j-1].g_fa.co;
        end
        full_adder u_fa (
          .a    (a),
          .b    (x_a[j] & y_a[i]),
          .cin  (ci),
          .sum  (s),
          .cout (co)
        );
      end
    end
  end

  // Each row retires its LSB.
  // The last row supplies the upper bits and the final carry.
  prod16_t prod;

  for (genvar i = 0; i < MULT8_W; i++) begin : g_lo
    assign prod[i] = g_row[i].g_col[0].s;
  end
  for (genvar j = 1; j < MULT8_W; j++) begin : g_hi
    assign prod[MULT8_W-1+j] = g_row[MULT8_W-1].g_col[j].s;
  end
  assign prod[MULT8_PW-1] = g_row[MULT8_W-1].g_col[MULT8_W-1].g_fa.co;

  prod16_t p_q, p_d;
  logic    out_valid_q, out_valid_d;

  // Load a new product only for qualified operands; otherwise hold it.
  always_comb begin
    p_d         = p_q;
    out_valid_d = v_a;
    if (v_a) begin
      p_d = prod;
    end
  end

  // Output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_mult8_gen.sv
// Directed and exhaustive check of array_mult8_gen.
// Build with ARRAY_MULT8_IN_REG_EN to test the 2-cycle variant.
module tb_array_mult8_gen;

`ifdef ARRAY_MULT8_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        in_valid;
  logic [15:0] P;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Expected-result pipeline. Index 0 holds the newest issue.
  logic        pv [2];
  logic [15:0] pe [2];
  logic [15:0] p_model;

  array_mult8_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .in_valid  (in_valid),
    .P         (P),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      pe[k] = 16'h0000;
    end
    p_model = 16'h0000;
  endtask

  // At each falling edge, check the result issued LAT steps earlier, then drive the next pair.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] e, input string tag);
    @(negedge clk);
    if (pv[LAT-1]) p_model = pe[LAT-1];
    chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, pv[LAT-1]});
    chk({tag, ".P"}, P, p_model);
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pe[k] = pe[k-1];
    end
    pv[0]    = v;
    pe[0]    = e;
    x        = a;
    y        = b;
    in_valid = v;
  endtask

  task automatic flush(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 16'h0000, tag);
  endtask

  // Assert reset between edges with all-ones valid operands; outputs must stay zero.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    x        = 8'hFF;
    y        = 8'hFF;
    in_valid = 1'b1;
    #1;
    chk({tag, ".P_async"}, P, 16'h0000);
    chk({tag, ".valid_async"}, {15'd0, out_valid}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, ".P_hold"}, P, 16'h0000);
      chk({tag, ".valid_hold"}, {15'd0, out_valid}, 16'h0000);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    clear_model();
  endtask

  initial begin
    rst_n    = 1'b0;
    x        = 8'hFF;
    y        = 8'hFF;
    in_valid = 1'b1;
    clear_model();

    do_reset("reset");
    flush(2, "post_reset");

    // Basic
    step(1'b1, 8'h02, 8'h02, 16'h0004, "basic");
    flush(LAT + 1, "basic_out");
    chk("basic.msb", {15'd0, P[15]}, 16'h0000);

    // Extremes, issued back to back
    step(1'b1, 8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    step(1'b1, 8'h00, 8'hAB, 16'h0000, "00_ab");
    step(1'b1, 8'h80, 8'h80, 16'h4000, "80_80");
    step(1'b1, 8'h01, 8'hC3, 16'h00C3, "01_c3");
    flush(LAT + 1, "ext_out");

    // Streaming: out_valid must stay high across the three results
    step(1'b1, 8'h03, 8'h05, 16'h000F, "stream0");
    step(1'b1, 8'h10, 8'h10, 16'h0100, "stream1");
    step(1'b1, 8'hFF, 8'h01, 16'h00FF, "stream2");
    flush(LAT + 1, "stream_out");

    // Hold: 0x34 * 0x59 = 0x1214, then idle with operands changing
    step(1'b1, 8'h34, 8'h59, 16'h1214, "hold");
    step(1'b0, 8'hAA, 8'h55, 16'h0000, "hold_idle0");
    step(1'b0, 8'h11, 8'h22, 16'h0000, "hold_idle1");
    flush(LAT + 1, "hold_out");
    chk("hold.P_final", P, 16'h1214);

    // Exhaustive, with a mid-stream reset halfway through
    for (int a = 0; a < 256; a++) begin
      if (a == 128) do_reset("mid_reset");
      for (int b = 0; b < 256; b++) begin
        step(1'b1, a[7:0], b[7:0], 16'(a * b), "exh");
      end
    end
    flush(LAT + 1, "exh_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
